// File: rtl/dmi_pkg.sv
// Shared DMI widths, request/response layouts and encodings for the
// debug-module interconnect.
package dmi_pkg;

   localparam int DmiReqWidth  = 41;
   localparam int DmiRespWidth = 34;

   typedef enum logic [1:0] {
      DmiOpNop   = 2'd0,
      DmiOpRead  = 2'd1,
      DmiOpWrite = 2'd2
   } dmi_op_e;

   typedef enum logic [1:0] {
      DmiRespOk     = 2'd0,
      DmiRespFailed = 2'd2,
      DmiRespBusy   = 2'd3
   } dmi_resp_e;

   typedef struct packed {
      logic [6:0]  addr;
      logic [31:0] data;
      dmi_op_e     op;
   } dmi_req_t;

   typedef struct packed {
      logic [31:0] data;
      dmi_resp_e   resp;
   } dmi_resp_t;

   // Arbiter grant-hold states.
   typedef enum logic {
      ArbFree = 1'b0,
      ArbHold = 1'b1
   } arb_state_e;

   // Index width that never collapses to zero bits.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/prim_fifo_sync.sv
// Single-clock FIFO with occupancy output; optional fall-through when empty.
module prim_fifo_sync
   import dmi_pkg::*;
#(
   parameter  int Width  = 1,
   parameter  int Depth  = 4,
   parameter  bit Pass   = 1'b0,
   localparam int DepthW = $clog2(Depth + 1)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              wvalid_i,
   output logic              wready_o,
   input  logic [Width-1:0]  wdata_i,
   output logic              rvalid_o,
   input  logic              rready_i,
   output logic [Width-1:0]  rdata_o,
   output logic [DepthW-1:0] depth_o
);

   localparam int PtrW = idx_width(Depth);

   logic [Width-1:0]  r_mem [Depth];
   logic [PtrW-1:0]   r_wptr;
   logic [PtrW-1:0]   r_rptr;
   logic [DepthW-1:0] r_cnt;

   logic w_empty;
   logic w_full;
   logic w_pass;
   logic w_push;
   logic w_pop;

   assign w_empty  = (r_cnt == '0);
   assign w_full   = (r_cnt == DepthW'(Depth));
   assign w_pass   = Pass && w_empty;

   assign wready_o = !w_full;
   assign rvalid_o = !w_empty || (w_pass && wvalid_i);
   assign rdata_o  = w_pass ? wdata_i : r_mem[r_rptr];
   assign depth_o  = r_cnt;

   // A fall-through word consumed in the same cycle never touches storage.
   assign w_push   = wvalid_i && !w_full && !(w_pass && rready_i);
   assign w_pop    = rready_i && !w_empty;

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem[r_wptr] <= wdata_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= (r_wptr == PtrW'(Depth - 1)) ? '0 : r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= (r_rptr == PtrW'(Depth - 1)) ? '0 : r_rptr + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_cnt <= r_cnt + 1'b1;
         end else if (!w_push && w_pop) begin
            r_cnt <= r_cnt - 1'b1;
         end
      end
   end

endmodule

// File: rtl/dmi_arb.sv
// Round-robin merge of several DMI hosts onto one debug-module port, with
// in-order response steering back to the issuing host.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ArbFree | no request stalled at the core; grant comes from the search
// ArbHold | last cycle's request was presented but not taken; keep grant
module dmi_arb
   import dmi_pkg::*;
#(
   parameter  int NumHosts       = 2,
   parameter  int ReqWidth       = DmiReqWidth,
   parameter  int RespWidth      = DmiRespWidth,
   parameter  int MaxOutstanding = 4,
   localparam int IdxW           = idx_width(NumHosts),
   localparam int CntW           = $clog2(MaxOutstanding + 1)
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic [NumHosts*ReqWidth-1:0] host_req_i,
   input  logic [NumHosts-1:0]          host_valid_i,
   output logic [NumHosts-1:0]          host_ready_o,
   output logic [RespWidth-1:0]         host_resp_o,
   output logic [NumHosts-1:0]          host_resp_valid_o,
   input  logic [NumHosts-1:0]          host_resp_ready_i,
   output logic [ReqWidth-1:0]          core_req_o,
   output logic                         core_valid_o,
   input  logic                         core_ready_i,
   input  logic [RespWidth-1:0]         core_resp_i,
   input  logic                         core_resp_valid_i,
   output logic                         core_resp_ready_o,
   output logic [CntW-1:0]              outstanding_o,
   output logic                         err_o
);

   arb_state_e r_state;
   arb_state_e w_state_nxt;

   logic [IdxW-1:0] r_ptr;
   logic [IdxW-1:0] r_hold_idx;
   logic [IdxW-1:0] w_search;
   logic [IdxW-1:0] w_grant;
   logic [IdxW-1:0] w_ptr_nxt;
   logic [IdxW-1:0] w_head;
   logic            w_id_wready;
   logic            w_id_full;
   logic            w_id_rvalid;
   logic            w_req_hs;
   logic            w_resp_hs;
   logic            r_err;

   always_comb begin
      logic            v_found;
      logic [IdxW-1:0] v_cand;
      v_found  = 1'b0;
      v_cand   = '0;
      w_search = r_ptr;
      for (int i = 0; i < NumHosts; i++) begin
         v_cand = IdxW'((int'(r_ptr) + i) % NumHosts);
         if (!v_found && host_valid_i[v_cand]) begin
            v_found  = 1'b1;
            w_search = v_cand;
         end
      end
   end

   assign w_grant = (r_state == ArbHold) ? r_hold_idx : w_search;

   always_comb begin
      w_state_nxt = ArbFree;
      if (core_valid_o && !core_ready_i) begin
         w_state_nxt = ArbHold;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= ArbFree;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Request path is held off while reset is asserted so the core never
   // sees a request the ID queue could not track.
   assign w_id_full    = !w_id_wready;
   assign core_req_o   = host_req_i[int'(w_grant)*ReqWidth +: ReqWidth];
   assign core_valid_o = rst_ni && host_valid_i[w_grant] && !w_id_full;
   assign w_req_hs     = core_valid_o && core_ready_i;
   assign w_ptr_nxt    = (w_grant == IdxW'(NumHosts - 1)) ? '0 : w_grant + 1'b1;

   always_comb begin
      host_ready_o          = '0;
      host_ready_o[w_grant] = rst_ni && core_ready_i && !w_id_full;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_ptr      <= '0;
         r_hold_idx <= '0;
      end else begin
         r_hold_idx <= w_grant;
         if (w_req_hs) begin
            r_ptr <= w_ptr_nxt;
         end
      end
   end

   prim_fifo_sync #(
      .Width (IdxW),
      .Depth (MaxOutstanding),
      .Pass  (1'b0)
   ) u_id_fifo (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .wvalid_i (w_req_hs),
      .wready_o (w_id_wready),
      .wdata_i  (w_grant),
      .rvalid_o (w_id_rvalid),
      .rready_i (w_resp_hs),
      .rdata_o  (w_head),
      .depth_o  (outstanding_o)
   );

   assign host_resp_o = core_resp_i;
   assign w_resp_hs   = w_id_rvalid && core_resp_valid_i && host_resp_ready_i[w_head];

   // With nothing outstanding the response has no owner: drain and flag it.
   always_comb begin
      host_resp_valid_o = '0;
      core_resp_ready_o = 1'b1;
      if (w_id_rvalid) begin
         host_resp_valid_o[w_head] = core_resp_valid_i;
         core_resp_ready_o         = host_resp_ready_i[w_head];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_err <= 1'b0;
      end else if (!w_id_rvalid && core_resp_valid_i) begin
         r_err <= 1'b1;
      end
   end

   assign err_o = r_err;

endmodule

// File: tb/tb_dmi_arb.sv
// Bench for dmi_arb: queue-based reference model checked every cycle, plus
// directed sequences with hand-computed expectations.
module tb_dmi_arb;

   localparam int N    = 2;
   localparam int RW   = 41;
   localparam int SW   = 34;
   localparam int MAXO = 4;
   localparam int CW   = 3;

   localparam logic [RW-1:0] R0 = 41'h0AA_1234_5678;
   localparam logic [RW-1:0] R1 = 41'h155_8765_4321;
   localparam logic [RW-1:0] R2 = 41'h0F0_CAFE_0001;
   localparam logic [RW-1:0] R3 = 41'h10F_BEEF_0002;

   logic          clk;
   logic          rst_n;
   logic [RW-1:0] hreq [N];
   logic [N*RW-1:0] host_req;
   logic [N-1:0]  host_valid;
   logic [N-1:0]  host_ready;
   logic [SW-1:0] host_resp;
   logic [N-1:0]  host_resp_valid;
   logic [N-1:0]  host_resp_ready;
   logic [RW-1:0] core_req;
   logic          core_valid;
   logic          core_ready;
   logic [SW-1:0] core_resp;
   logic          core_resp_valid;
   logic          core_resp_ready;
   logic [CW-1:0] outstanding;
   logic          err;

   for (genvar g = 0; g < N; g++) begin : g_pack
      assign host_req[g*RW +: RW] = hreq[g];
   end

   dmi_arb #(
      .NumHosts       (N),
      .ReqWidth       (RW),
      .RespWidth      (SW),
      .MaxOutstanding (MAXO)
   ) dut (
      .clk_i             (clk),
      .rst_ni            (rst_n),
      .host_req_i        (host_req),
      .host_valid_i      (host_valid),
      .host_ready_o      (host_ready),
      .host_resp_o       (host_resp),
      .host_resp_valid_o (host_resp_valid),
      .host_resp_ready_i (host_resp_ready),
      .core_req_o        (core_req),
      .core_valid_o      (core_valid),
      .core_ready_i      (core_ready),
      .core_resp_i       (core_resp),
      .core_resp_valid_i (core_resp_valid),
      .core_resp_ready_o (core_resp_ready),
      .outstanding_o     (outstanding),
      .err_o             (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: FIFO of issuing hosts, rotating priority, stalled-host hold.
   int           mq[$];
   int           m_ptr;
   int           m_lock;
   bit           m_err;
   logic [N-1:0] accepted;

   always @(negedge clk) begin
      int           g;
      int           h;
      bit           full;
      bit           ev;
      bit           found;
      bit           exp_crr;
      bit           pop_now;
      logic [N-1:0] er;
      logic [N-1:0] erv;
      if (!rst_n) begin
         mq.delete();
         m_ptr    = 0;
         m_lock   = -1;
         m_err    = 1'b0;
         accepted = '0;
         chk("rst_core_valid", core_valid, 0);
         chk("rst_host_ready", host_ready, 0);
         chk("rst_resp_valid", host_resp_valid, 0);
         chk("rst_resp_ready", core_resp_ready, 1);
         chk("rst_outstanding", outstanding, 0);
         chk("rst_err", err, 0);
      end else begin
         full = (mq.size() == MAXO);
         if (m_lock >= 0) begin
            g = m_lock;
         end else begin
            g     = m_ptr;
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
               if (!found && host_valid[(m_ptr + k) % N]) begin
                  found = 1'b1;
                  g     = (m_ptr + k) % N;
               end
            end
         end
         ev = host_valid[g] && !full;
         chk("m_core_valid", core_valid, ev);
         if (ev) chk("m_core_req", core_req, hreq[g]);
         er = '0;
         if (core_ready && !full) er[g] = 1'b1;
         chk("m_host_ready", host_ready & host_valid, er & host_valid);
         erv     = '0;
         exp_crr = 1'b1;
         h       = 0;
         if (mq.size() > 0) begin
            h       = mq[0];
            erv[h]  = core_resp_valid;
            exp_crr = host_resp_ready[h];
         end
         chk("m_resp_valid", host_resp_valid, erv);
         chk("m_resp_ready", core_resp_ready, exp_crr);
         if (|erv) chk("m_resp_data", host_resp, core_resp);
         chk("m_outstanding", outstanding, mq.size());
         chk("m_err", err, m_err);

         accepted = '0;
         pop_now  = (mq.size() > 0) && core_resp_valid && host_resp_ready[h];
         if (mq.size() == 0 && core_resp_valid) m_err = 1'b1;
         m_lock = (ev && !core_ready) ? g : -1;
         if (pop_now) void'(mq.pop_front());
         if (ev && core_ready) begin
            accepted[g] = 1'b1;
            m_ptr       = (g + 1) % N;
            mq.push_back(g);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      host_valid      = '0;
      core_ready      = 1'b0;
      core_resp_valid = 1'b0;
      host_resp_ready = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n   = 1'b0;
      hreq[0] = R0;
      hreq[1] = R1;
      core_resp = '0;
      idle_inputs();
      do_reset();

      // Reset state.
      smp();
      chk("t1_outstanding", outstanding, 0);
      chk("t1_resp_ready", core_resp_ready, 1);
      chk("t1_err", err, 0);
      chk("t1_core_valid", core_valid, 0);
      chk("t1_resp_valid", host_resp_valid, 0);
      step();

      // Both hosts busy, core always ready, response one cycle later.
      host_valid      = 2'b11;
      core_ready      = 1'b1;
      host_resp_ready = 2'b11;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) begin
            core_resp_valid = 1'b1;
            core_resp       = SW'({$urandom(), $urandom()});
         end
         smp();
         chk("t2_core_req", core_req, (i % 2) ? R1 : R0);
         chk("t2_outstanding", outstanding, (i > 0) ? 1 : 0);
         if (i > 0) chk("t2_resp_onehot", host_resp_valid, ((i - 1) % 2) ? 2'b10 : 2'b01);
         step();
      end
      host_valid = '0;
      smp();
      chk("t2_last_resp", host_resp_valid, 2'b10);
      step();
      core_resp_valid = 1'b0;

      // Stalled request must not be preempted by a newly valid host.
      host_valid = 2'b01;
      step();
      host_valid      = 2'b00;
      core_resp_valid = 1'b1;
      step();
      core_resp_valid = 1'b0;
      core_ready      = 1'b0;
      hreq[0]         = R2;
      hreq[1]         = R3;
      host_valid      = 2'b01;
      smp();
      chk("t3_req_c0", core_req, R2);
      step();
      host_valid = 2'b11;
      for (int i = 1; i < 3; i++) begin
         smp();
         chk("t3_req_held", core_req, R2);
         chk("t3_no_ready", host_ready, 2'b00);
         step();
      end
      core_ready = 1'b1;
      smp();
      chk("t3_req_accept", core_req, R2);
      chk("t3_ready0", host_ready, 2'b01);
      step();
      host_valid = 2'b10;
      smp();
      chk("t3_req_next", core_req, R3);
      chk("t3_ready1", host_ready, 2'b10);
      step();
      host_valid      = '0;
      core_ready      = 1'b0;
      core_resp_valid = 1'b1;
      smp();
      chk("t3_resp0", host_resp_valid, 2'b01);
      step();
      smp();
      chk("t3_resp1", host_resp_valid, 2'b10);
      step();
      core_resp_valid = 1'b0;

      // Outstanding limit.
      hreq[0]    = R0;
      host_valid = 2'b01;
      core_ready = 1'b1;
      repeat (MAXO) step();
      smp();
      chk("t4_full_cnt", outstanding, MAXO);
      chk("t4_full_valid", core_valid, 0);
      chk("t4_full_ready", host_ready, 2'b00);
      step();
      core_resp_valid = 1'b1;
      smp();
      chk("t4_pop_blocks_push", core_valid, 0);
      chk("t4_pop_resp", host_resp_valid, 2'b01);
      step();
      core_resp_valid = 1'b0;
      smp();
      chk("t4_after_pop_cnt", outstanding, MAXO - 1);
      chk("t4_after_pop_valid", core_valid, 1);
      step();
      host_valid = '0;
      smp();
      chk("t4_refill", outstanding, MAXO);
      step();

      // Response backpressure from the owning host.
      core_resp_valid = 1'b1;
      host_resp_ready = 2'b10;
      for (int i = 0; i < 2; i++) begin
         smp();
         chk("t5_stall_ready", core_resp_ready, 0);
         chk("t5_stall_onehot", host_resp_valid, 2'b01);
         chk("t5_stall_cnt", outstanding, MAXO);
         step();
      end
      host_resp_ready = 2'b11;
      smp();
      chk("t5_release", core_resp_ready, 1);
      repeat (MAXO) step();
      core_resp_valid = 1'b0;
      smp();
      chk("t5_drained", outstanding, 0);
      chk("t5_err_clear", err, 0);
      step();

      // Orphan response sets the sticky error.
      core_resp_valid = 1'b1;
      smp();
      chk("t6_orphan_ready", core_resp_ready, 1);
      chk("t6_orphan_novalid", host_resp_valid, 2'b00);
      chk("t6_err_before", err, 0);
      step();
      core_resp_valid = 1'b0;
      smp();
      chk("t6_err_set", err, 1);
      step();
      host_valid = 2'b11;
      repeat (2) step();
      host_valid      = '0;
      core_resp_valid = 1'b1;
      repeat (2) step();
      core_resp_valid = 1'b0;
      smp();
      chk("t6_err_sticky", err, 1);
      step();

      // Asynchronous reset with requests in flight.
      host_valid = 2'b11;
      core_ready = 1'b1;
      repeat (2) step();
      core_ready = 1'b0;
      smp();
      chk("t7_two_out", outstanding, 2);
      step();
      core_resp_valid = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("t7_rst_cnt", outstanding, 0);
      chk("t7_rst_valid", core_valid, 0);
      chk("t7_rst_ready", host_ready, 2'b00);
      chk("t7_rst_err", err, 0);
      chk("t7_rst_resp_ready", core_resp_ready, 1);
      chk("t7_rst_resp_valid", host_resp_valid, 2'b00);
      idle_inputs();
      @(posedge clk);
      #3 rst_n = 1'b1;
      step();

      // Randomized traffic under the model; hosts hold until accepted.
      for (int c = 0; c < 4000; c++) begin
         for (int h = 0; h < N; h++) begin
            if (!host_valid[h] || accepted[h]) begin
               host_valid[h] = ($urandom_range(0, 99) < 60);
               hreq[h]       = RW'({$urandom(), $urandom()});
            end
         end
         core_ready      = ($urandom_range(0, 99) < 70);
         host_resp_ready = N'($urandom_range(0, 3));
         core_resp       = SW'({$urandom(), $urandom()});
         core_resp_valid = (mq.size() > 0) && ($urandom_range(0, 99) < 50);
         step();
      end
      smp();
      chk("t8_err_never", err, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
